xor_stream_cipher: RTL and testbench

XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

---
 rtl/xor_cipher_pkg.sv | 24 ++
 rtl/xor_lane.sv | 40 ++++
 rtl/xor_stream_cipher.sv | 184 ++++++++++++++++++
 tb/tb_xor_stream_cipher.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_pkg
//
// Purpose : Shared types and constants for the XOR stream cipher block.
//           Holds the controller state encoding and the key-mode constants
//           used by the top level and its combinational lane slice.
//
// Contents:
//   state_t    - controller states (IDLE, PROCESS, OUT)
//   MODE_FIXED - key register is left untouched between words
//   MODE_ROLL  - key register rotates left by one bit after each word
// ---------------------------------------------------------------------------
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_ROLL  = 1'b1;

endpackage : xor_cipher_pkg

// File: rtl/xor_lane.sv
// ---------------------------------------------------------------------------
// xor_lane
//
// Purpose : Combinational LANES-bit slice of the cipher. For beat b it
//           XORs plaintext bit j with key bit ((b*LANES + j) mod KEY_W),
//           so the key repeats cyclically across the whole word no matter
//           how the word is cut into beats.
//
// Ports   :
//   i_beat [BCNT_W-1:0] - current beat index inside the word
//   i_pt   [LANES-1:0]  - plaintext slice for this beat
//   i_key  [KEY_W-1:0]  - current key register contents
//   o_ct   [LANES-1:0]  - ciphertext slice for this beat
// ---------------------------------------------------------------------------
module xor_lane #(
    parameter int LANES  = 4,
    parameter int KEY_W  = 8,
    parameter int BCNT_W = 2
) (
    input  logic [BCNT_W-1:0] i_beat,
    input  logic [LANES-1:0]  i_pt,
    input  logic [KEY_W-1:0]  i_key,
    output logic [LANES-1:0]  o_ct
);

    localparam int KIDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    logic [KIDX_W-1:0] w_kidx;

    always_comb begin
        o_ct   = '0;
        w_kidx = '0;
        for (int j = 0; j < LANES; j++) begin
            // Absolute bit position in the word, folded onto the key length.
            w_kidx  = KIDX_W'((int'(i_beat) * LANES + j) % KEY_W);
            o_ct[j] = i_pt[j] ^ i_key[w_kidx];
        end
    end

endmodule : xor_lane

// File: rtl/xor_stream_cipher.sv
// ---------------------------------------------------------------------------
// xor_stream_cipher
//
// Purpose : Multi-cycle XOR stream cipher. A plaintext word is accepted in
//           IDLE, enciphered LANES bits per cycle over BEATS = WORD_W/LANES
//           cycles in PROCESS, then presented in OUT until the sink takes
//           it. Decryption is the same operation with the same key sequence.
//           In rolling mode the key rotates left by one bit after every
//           delivered word.
//
// Ports   :
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   key_load   - load `key` into the key register (honoured in IDLE only)
//   key        - key value [KEY_W-1:0]
//   mode       - 0 fixed key, 1 rolling key (captured with the word)
//   in_valid   - plaintext word offered
//   in_ready   - block can accept a word (high only in IDLE)
//   plaintext  - word to encipher [WORD_W-1:0]
//   out_valid  - ciphertext valid (registered)
//   out_ready  - sink accepts ciphertext
//   ciphertext - result [WORD_W-1:0], held until the next accept
//   done       - one-cycle pulse after each output handshake
// ---------------------------------------------------------------------------
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int KEY_W  = 8,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] plaintext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] ciphertext,
    output logic              done
);

    localparam int BEATS  = WORD_W / LANES;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject geometries where the word does not split into whole beats.
    generate
        if ((LANES < 1) || (KEY_W < 1) || ((WORD_W % LANES) != 0)) begin : g_param_err
            $error("xor_stream_cipher: illegal WORD_W/LANES/KEY_W combination");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              r_state;
    logic [BCNT_W-1:0]   r_beat;
    logic [WORD_W-1:0]   r_pt;
    logic [WORD_W-1:0]   r_ct;
    logic [KEY_W-1:0]    r_key;
    logic                r_mode;
    logic                r_out_valid;
    logic                r_done;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_handshake;
    logic                w_last_beat;
    logic [LANES-1:0]    w_pt_slice;
    logic [LANES-1:0]    w_ct_slice;
    logic [KEY_W-1:0]    w_key_rot;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = (r_state == ST_OUT) && out_ready;
    assign w_last_beat = (r_beat == BCNT_W'(BEATS - 1));

    assign out_valid   = r_out_valid;
    assign ciphertext  = r_ct;
    assign done        = r_done;

    // Rotate-left by one; a single-bit key rotates onto itself.
    generate
        if (KEY_W == 1) begin : g_rot_id
            assign w_key_rot = r_key;
        end else begin : g_rot_l1
            assign w_key_rot = {r_key[KEY_W-2:0], r_key[KEY_W-1]};
        end
    endgenerate

    assign w_pt_slice = r_pt[int'(r_beat) * LANES +: LANES];

    xor_lane #(
        .LANES  (LANES),
        .KEY_W  (KEY_W),
        .BCNT_W (BCNT_W)
    ) u_lane (
        .i_beat (r_beat),
        .i_pt   (w_pt_slice),
        .i_key  (r_key),
        .o_ct   (w_ct_slice)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_pt        <= '0;
            r_ct        <= '0;
            r_key       <= '0;
            r_mode      <= MODE_FIXED;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_handshake;

            if (w_accept) begin
                r_pt   <= plaintext;
                r_mode <= mode;
                r_ct   <= '0;
                r_beat <= '0;
            end

            if (r_state == ST_PROCESS) begin
                r_ct[int'(r_beat) * LANES +: LANES] <= w_ct_slice;
                if (w_last_beat) begin
                    r_out_valid <= 1'b1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end

            if (w_handshake) begin
                r_out_valid <= 1'b0;
            end

            // A key loaded on the accept edge is already in place for the
            // first PROCESS beat, so it applies to that same word.
            if ((r_state == ST_IDLE) && key_load) begin
                r_key <= key;
            end else if (w_handshake && (r_mode == MODE_ROLL)) begin
                r_key <= w_key_rot;
            end
        end
    end

endmodule : xor_stream_cipher

// File: tb/tb_xor_stream_cipher.sv
// ---------------------------------------------------------------------------
// tb_xor_stream_cipher
//
// Directed bench for xor_stream_cipher. Three instances share one stimulus
// bus: the default geometry (16/8/4), a 5-bit key variant and a single-beat
// (LANES=16) variant. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_xor_stream_cipher;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        key_load;
    logic [7:0]  key;
    logic        mode;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] plaintext;

    logic        in_ready_a, out_valid_a, done_a;
    logic [15:0] ct_a;
    logic        in_ready_b, out_valid_b, done_b;
    logic [15:0] ct_b;
    logic        in_ready_c, out_valid_c, done_c;
    logic [15:0] ct_c;

    int checks   = 0;
    int failures = 0;

    logic [15:0] pts_c [3] = '{16'hA5A5, 16'h0000, 16'hFFFF};
    logic [15:0] exp_c [3] = '{16'h9999, 16'h3C3C, 16'hC3C3};

    xor_stream_cipher #(.WORD_W(16), .KEY_W(8), .LANES(4)) u_dut_a (
        .clk(clk), .reset(reset), .key_load(key_load), .key(key), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .plaintext(plaintext),
        .out_valid(out_valid_a), .out_ready(out_ready), .ciphertext(ct_a),
        .done(done_a)
    );

    xor_stream_cipher #(.WORD_W(16), .KEY_W(5), .LANES(4)) u_dut_b (
        .clk(clk), .reset(reset), .key_load(key_load), .key(key[4:0]), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .plaintext(plaintext),
        .out_valid(out_valid_b), .out_ready(out_ready), .ciphertext(ct_b),
        .done(done_b)
    );

    xor_stream_cipher #(.WORD_W(16), .KEY_W(8), .LANES(16)) u_dut_c (
        .clk(clk), .reset(reset), .key_load(key_load), .key(key), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_c), .plaintext(plaintext),
        .out_valid(out_valid_c), .out_ready(out_ready), .ciphertext(ct_c),
        .done(done_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until out_valid of the default instance, bounded.
    task automatic wait_valid_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid_a && n < 20);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        key_load  = 1'b0;
        key       = 8'h00;
        mode      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = 16'h0000;
        tick();
        reset = 1'b1;
    endtask

    task automatic offer_word(input logic [15:0] pt, input logic md, input logic ld, input logic [7:0] k);
        plaintext = pt;
        mode      = md;
        key_load  = ld;
        key       = k;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        key_load  = 1'b0;
    endtask

    task automatic handshake_a(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_done"}, done_a, 1'b1);
        check_eq({tag, "_ovld_drop"}, out_valid_a, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        reset = 1'b0; key_load = 1'b0; key = 8'h00; mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; plaintext = 16'h0000;
        #2;
        check_eq("rst_in_ready_a", in_ready_a, 1'b1);
        check_eq("rst_out_valid_a", out_valid_a, 1'b0);
        check_eq("rst_done_a", done_a, 1'b0);
        check_eq("rst_ct_a", ct_a, 16'h0000);
        check_eq("rst_in_ready_b", in_ready_b, 1'b1);
        check_eq("rst_ct_b", ct_b, 16'h0000);
        check_eq("rst_in_ready_c", in_ready_c, 1'b1);
        check_eq("rst_out_valid_c", out_valid_c, 1'b0);
        tick();
        reset = 1'b1;

        // Fixed key, key loaded on the accept edge
        offer_word(16'hA5A5, 1'b0, 1'b1, 8'h3C);
        check_eq("fix_in_ready_busy", in_ready_a, 1'b0);
        check_eq("fix_ct_cleared", ct_a, 16'h0000);
        wait_valid_a(n);
        check_eq("fix_latency", n, 4);
        check_eq("fix_ct", ct_a, 16'h9999);
        check_eq("fix_no_early_done", done_a, 1'b0);
        handshake_a("fix");
        check_eq("fix_in_ready_back", in_ready_a, 1'b1);
        tick();
        check_eq("fix_done_one_cycle", done_a, 1'b0);
        check_eq("fix_ct_retained", ct_a, 16'h9999);

        // Rolling key
        apply_reset();
        offer_word(16'hA5A5, 1'b1, 1'b1, 8'h3C);
        wait_valid_a(n);
        check_eq("roll_ct0", ct_a, 16'h9999);
        handshake_a("roll0");
        offer_word(16'h0000, 1'b1, 1'b0, 8'h00);
        check_eq("roll_ct_cleared", ct_a, 16'h0000);
        wait_valid_a(n);
        check_eq("roll_latency", n, 4);
        check_eq("roll_ct1", ct_a, 16'h7878);
        handshake_a("roll1");

        // Key length that does not divide the word
        apply_reset();
        offer_word(16'h0000, 1'b0, 1'b1, 8'h16);
        wait_valid_a(n);
        check_eq("k5_ct", ct_b, 16'h5AD6);
        check_eq("k5_valid", out_valid_b, 1'b1);
        check_eq("k8_ct_same_key", ct_a, 16'h1616);
        handshake_a("k5");

        // Back-pressure in OUT, with key_load and in_valid attempted meanwhile
        apply_reset();
        offer_word(16'hA5A5, 1'b0, 1'b1, 8'h3C);
        wait_valid_a(n);
        for (int i = 0; i < 10; i++) begin
            key_load  = 1'b1;
            key       = 8'hFF;
            in_valid  = 1'b1;
            plaintext = 16'h1234;
            tick();
            check_eq("stall_ct", ct_a, 16'h9999);
            check_eq("stall_in_ready", in_ready_a, 1'b0);
            check_eq("stall_done", done_a, 1'b0);
            check_eq("stall_ovld", out_valid_a, 1'b1);
        end
        key_load = 1'b0;
        in_valid = 1'b0;
        handshake_a("stall");
        offer_word(16'h0000, 1'b0, 1'b0, 8'h00);
        wait_valid_a(n);
        check_eq("stall_key_kept", ct_a, 16'h3C3C);
        handshake_a("stall2");

        // Reset in the middle of PROCESS
        apply_reset();
        offer_word(16'hA5A5, 1'b0, 1'b1, 8'h3C);
        tick();
        tick();
        check_eq("mid_partial_ct", ct_a, 16'h0099);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ct", ct_a, 16'h0000);
        check_eq("mid_rst_ovld", out_valid_a, 1'b0);
        check_eq("mid_rst_in_ready", in_ready_a, 1'b1);
        check_eq("mid_rst_done", done_a, 1'b0);
        tick();
        reset = 1'b1;
        offer_word(16'h5A5A, 1'b0, 1'b1, 8'h3C);
        wait_valid_a(n);
        check_eq("mid_next_latency", n, 4);
        check_eq("mid_next_ct", ct_a, 16'h6666);
        handshake_a("mid");

        // Single-beat instance, back-to-back words
        apply_reset();
        out_ready = 1'b1;
        key       = 8'h3C;
        mode      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            key_load  = (k == 0);
            plaintext = pts_c[k];
            in_valid  = 1'b1;
            check_eq("b2b_in_ready", in_ready_c, 1'b1);
            tick();
            key_load = 1'b0;
            check_eq("b2b_not_yet_valid", out_valid_c, 1'b0);
            tick();
            check_eq("b2b_valid", out_valid_c, 1'b1);
            check_eq("b2b_ct", ct_c, exp_c[k]);
            tick();
            check_eq("b2b_done", done_c, 1'b1);
            check_eq("b2b_ovld_drop", out_valid_c, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_xor_stream_cipher
